inst_rom: RTL and testbench

INST_ROM -- requirements
Module: inst_rom

---
 rtl/inst_rom_pkg.sv | 6 +
 rtl/inst_rom.sv | 76 +++++++
 tb/tb_inst_rom.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/inst_rom_pkg.sv
// inst_rom_pkg: shared defines for the instruction ROM (NOP value, default depth, FSM states)
package inst_rom_pkg;
  localparam int DEPTH_LOG2_DEF = 8;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic [1:0] {EMPTY = 2'd0, LOAD = 2'd1, READY = 2'd2} state_t;
endpackage

// File: rtl/inst_rom.sv
// inst_rom: byte-loaded instruction store with a zero-latency fetch port
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           addr,
  output logic [31:0]           inst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_end,
  output logic                  load_ready,
  output logic                  loaded,
  output logic [DEPTH_LOG2:0]   word_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = DEPTH[DEPTH_LOG2:0];
  state_t state, state_next;
  logic [1:0] byte_cnt, bc_acc, bc_next;
  logic [31:0] asm_reg, asm_acc, asm_next;
  logic [DEPTH_LOG2:0] cnt_acc, cnt_next;
  logic accept, wr_en;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] mem [DEPTH];
  logic unused_addr;
  assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
  assign idx = addr[DEPTH_LOG2+1:2];
  assign loaded = state == READY;
  assign inst = (ce && loaded && {1'b0, idx} < word_cnt) ? mem[idx] : NOP;
  // Byte assembly, word commit and next-state selection; load_start overrides everything
  always_comb begin
    load_ready = state == LOAD && word_cnt != FULL;
    accept = load_valid && load_ready;
    asm_acc = accept ? asm_reg | ({load_byte, 24'h0} >> {byte_cnt, 3'b000}) : asm_reg;
    bc_acc = byte_cnt + 2'(accept);
    wr_en = state == LOAD && !load_start && ((accept && byte_cnt == 2'd3) || (load_end && bc_acc != 2'd0));
    cnt_acc = word_cnt + (DEPTH_LOG2+1)'(wr_en);
    state_next = state;
    cnt_next = word_cnt;
    bc_next = byte_cnt;
    asm_next = asm_reg;
    if (load_start) begin
      state_next = LOAD;
      cnt_next = '0;
      bc_next = '0;
      asm_next = '0;
    end else if (state == LOAD) begin
      cnt_next = cnt_acc;
      bc_next = load_end ? 2'd0 : bc_acc;
      asm_next = (wr_en || load_end) ? 32'h0 : asm_acc;
      state_next = (load_end || cnt_acc == FULL) ? READY : LOAD;
    end
  end
  // Control state; reset abandons any load in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_reg <= '0;
    end else begin
      state <= state_next;
      word_cnt <= cnt_next;
      byte_cnt <= bc_next;
      asm_reg <= asm_next;
    end
  end
  // Storage array is left unreset; word_cnt gating hides stale words
  always_ff @(posedge clk) begin
    if (wr_en) mem[word_cnt[DEPTH_LOG2-1:0]] <= asm_acc;
  end
endmodule

// File: tb/tb_inst_rom.sv
// tb_inst_rom: scoreboard bench for inst_rom using directed load/fetch vectors
module tb_inst_rom;
  logic clk = 1'b0, rst = 1'b0, ce = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] inst;
  logic load_start = 1'b0, load_valid = 1'b0, load_end = 1'b0;
  logic [7:0] load_byte = '0;
  logic load_ready, loaded;
  logic [8:0] word_cnt;
  typedef struct packed {
    logic [31:0] inst;
    logic loaded;
    logic [8:0] cnt;
    logic rdy;
  } exp_t;
  exp_t q_exp[$];
  string q_name[$];
  int errors = 0, checks = 0;

  inst_rom dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_end(load_end), .load_ready(load_ready), .loaded(loaded), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: pop one expectation per falling edge and compare every output
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      string n;
      e = q_exp.pop_front();
      n = q_name.pop_front();
      checks += 4;
      if (inst !== e.inst) begin errors++; $display("FAIL %s inst got=%h exp=%h", n, inst, e.inst); end
      if (loaded !== e.loaded) begin errors++; $display("FAIL %s loaded got=%b exp=%b", n, loaded, e.loaded); end
      if (word_cnt !== e.cnt) begin errors++; $display("FAIL %s word_cnt got=%0d exp=%0d", n, word_cnt, e.cnt); end
      if (load_ready !== e.rdy) begin errors++; $display("FAIL %s load_ready got=%b exp=%b", n, load_ready, e.rdy); end
    end
  end

  task automatic expect_out(input string n, input logic [31:0] i, input logic l, input logic [8:0] c, input logic r);
    q_exp.push_back({i, l, c, r});
    q_name.push_back(n);
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input string n, input logic [31:0] a, input logic [31:0] i, input logic [8:0] c);
    addr = a;
    expect_out(n, i, 1'b1, c, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic finish_load();
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
  endtask

  initial begin
    logic [7:0] img [8];
    img = '{8'h34, 8'h02, 8'h00, 8'h05, 8'h34, 8'h03, 8'h00, 8'h07};
    #2;
    expect_out("reset", 32'h0, 1'b0, 9'd0, 1'b0);
    rst = 1'b1;
    tick();
    start();
    expect_out("load_idle", 32'h0, 1'b0, 9'd0, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) send(img[i]);
    finish_load();
    fetch("w0", 32'h0, 32'h3402_0005, 9'd2);
    fetch("w1", 32'h4, 32'h3403_0007, 9'd2);
    fetch("beyond_cnt", 32'h8, 32'h0, 9'd2);
    fetch("byte_offset", 32'h7, 32'h3403_0007, 9'd2);
    ce = 1'b0;
    fetch("ce_off", 32'h0, 32'h0, 9'd2);
    ce = 1'b1;
    fetch("ce_on", 32'h0, 32'h3402_0005, 9'd2);
    start();
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'h11); send(8'h22);
    finish_load();
    fetch("partial_w0", 32'h0, 32'hAABB_CCDD, 9'd2);
    fetch("partial_w1", 32'h4, 32'h1122_0000, 9'd2);
    start();
    for (int i = 1; i <= 5; i++) send(8'(i));
    load_end = 1'b1;
    send(8'h06);
    load_end = 1'b0;
    fetch("end_byte_w1", 32'h4, 32'h0506_0000, 9'd2);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_byte = 8'h12;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    finish_load();
    fetch("start_drop_w0", 32'h0, 32'hDEAD_BEEF, 9'd1);
    fetch("start_drop_w1", 32'h4, 32'h0, 9'd1);
    start();
    for (int w = 0; w < 256; w++) begin
      send(8'(w)); send(~8'(w)); send(8'hA5);
      if (w == 255) expect_out("last_byte_pending", 32'h0, 1'b0, 9'd255, 1'b1);
      send(8'h5A);
    end
    fetch("full_wrap", 32'h400, 32'h00FF_A55A, 9'd256);
    fetch("full_last", 32'h3FC, 32'hFF00_A55A, 9'd256);
    fetch("full_mid", 32'h204, 32'h817E_A55A, 9'd256);
    send(8'h77);
    fetch("valid_in_ready", 32'h0, 32'h00FF_A55A, 9'd256);
    start();
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    rst = 1'b0;
    expect_out("async_reset", 32'h0, 1'b0, 9'd0, 1'b0);
    rst = 1'b1;
    tick();
    finish_load();
    expect_out("after_reset", 32'h0, 1'b0, 9'd0, 1'b0);
    start();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    finish_load();
    fetch("reload", 32'h0, 32'h0102_0304, 9'd1);
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
